// File: rtl/cu_pkg.sv
// Shared state codes, opcode constants and retire decode for the multicycle
// RV32I control-unit sequencer.
package cu_pkg;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_ALU_WB    = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP_ADDR = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_AUIPC     = 4'd11;
  localparam logic [3:0] S_JALR      = 4'd12;
  localparam logic [3:0] S_I_EXEC    = 4'd13;
  localparam logic [3:0] S_LUI       = 4'd14;
  localparam logic [3:0] S_TRAP      = 4'd15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // States that always end an instruction; MEM_WRITE retires only once memory is done.
  function automatic logic is_retire_state(input logic [3:0] s);
    return (s == S_MEM_WB) || (s == S_ALU_WB) || (s == S_BRANCH) ||
           (s == S_JAL)    || (s == S_JALR);
  endfunction

endpackage

// File: rtl/cu_next_state_logic.sv
// Purely combinational next-state function of the control unit:
// (state, op, mem_ready) -> ns.
module cu_next_state_logic
  import cu_pkg::*;
#(
  parameter int STATE_W  = 4,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic [STATE_W-1:0] state,
  input  logic [6:0]         op,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] ns
);

  logic       hi_nz;
  logic       wait_done;
  logic [3:0] ns_code;

  // Encodings above 15 exist only for wide state registers and are never legal.
  assign hi_nz     = (state >> 4) != '0;
  assign wait_done = !MEM_WAIT || mem_ready;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ns_code = S_TRAP;
    if (!hi_nz) begin
      case (state[3:0])
        S_FETCH:     ns_code = wait_done ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: ns_code = S_MEM_ADDR;
            OP_R:              ns_code = S_R_EXEC;
            OP_BRANCH:         ns_code = S_BRANCH;
            OP_JAL, OP_JALR:   ns_code = S_JUMP_ADDR;
            OP_AUIPC:          ns_code = S_AUIPC;
            OP_IMM:            ns_code = S_I_EXEC;
            OP_LUI:            ns_code = S_LUI;
            default:           ns_code = S_TRAP;
          endcase
        end
        S_MEM_ADDR: begin
          if (op == OP_LOAD)       ns_code = S_MEM_READ;
          else if (op == OP_STORE) ns_code = S_MEM_WRITE;
          else                     ns_code = S_TRAP;
        end
        S_MEM_READ:  ns_code = wait_done ? S_MEM_WB : S_MEM_READ;
        S_MEM_WRITE: ns_code = wait_done ? S_FETCH : S_MEM_WRITE;
        S_JUMP_ADDR: begin
          if (op == OP_JAL)       ns_code = S_JAL;
          else if (op == OP_JALR) ns_code = S_JALR;
          else                    ns_code = S_TRAP;
        end
        S_R_EXEC, S_I_EXEC, S_AUIPC, S_LUI:          ns_code = S_ALU_WB;
        S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL, S_JALR: ns_code = S_FETCH;
        default:                                     ns_code = S_TRAP;
      endcase
    end
    ns      = '0;
    ns[3:0] = ns_code;
  end

endmodule

// File: rtl/multicycle_cu_fsm.sv
// Multicycle RV32I control-unit sequencer: state register, retire/trap decode
// and retired-instruction counter around the next-state logic.
module multicycle_cu_fsm
  import cu_pkg::*;
#(
  parameter int STATE_W  = 4,
  parameter int CNT_W    = 32,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] ns,
  output logic               retire,
  output logic [CNT_W-1:0]   instret,
  output logic               trap
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               lo_only;
  logic               wait_done;

  cu_next_state_logic #(
    .STATE_W  (STATE_W),
    .MEM_WAIT (MEM_WAIT)
  ) u_next_state (
    .state     (state_q),
    .op        (op),
    .mem_ready (mem_ready),
    .ns        (state_d)
  );

  assign lo_only   = (state_q >> 4) == '0;
  assign wait_done = !MEM_WAIT || mem_ready;

  // A store retires on the cycle its write is accepted, not on every wait cycle.
  assign retire = lo_only && (is_retire_state(state_q[3:0]) ||
                              (state_q[3:0] == S_MEM_WRITE && wait_done));
  assign trap   = lo_only && (state_q[3:0] == S_TRAP);

  assign instret_d = instret_q + CNT_W'(retire);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      state_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign ns      = state_d;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_cu_fsm.sv
// Self-checking bench: per-instruction expected state traces drive a per-cycle
// compare process, plus literal spot checks and parameter-variant instances.
module tb_multicycle_cu_fsm;
  import cu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration
  logic        reset, mem_ready;
  logic [6:0]  op;
  logic [3:0]  state, ns;
  logic        retire, trap;
  logic [31:0] instret;

  multicycle_cu_fsm #(.STATE_W(4), .CNT_W(32), .MEM_WAIT(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .state(state), .ns(ns), .retire(retire), .instret(instret), .trap(trap)
  );

  // Narrow counter for wrap-around
  logic        reset_c, rdy_c;
  logic [6:0]  op_c;
  logic [3:0]  state_c, ns_c, instret_c;
  logic        retire_c, trap_c;

  multicycle_cu_fsm #(.STATE_W(4), .CNT_W(4), .MEM_WAIT(1'b1)) dut_c (
    .clk(clk), .reset(reset_c), .op(op_c), .mem_ready(rdy_c),
    .state(state_c), .ns(ns_c), .retire(retire_c), .instret(instret_c), .trap(trap_c)
  );

  // Wide state register, memory wait disabled
  logic        reset_w, rdy_w;
  logic [6:0]  op_w;
  logic [5:0]  state_w, ns_w;
  logic        retire_w, trap_w;
  logic [31:0] instret_w;

  multicycle_cu_fsm #(.STATE_W(6), .CNT_W(32), .MEM_WAIT(1'b0)) dut_w (
    .clk(clk), .reset(reset_w), .op(op_w), .mem_ready(rdy_w),
    .state(state_w), .ns(ns_w), .retire(retire_w), .instret(instret_w), .trap(trap_w)
  );

  // Bare next-state logic so an unused encoding can be presented directly
  logic [5:0] nsl_state, nsl_ns;
  logic [6:0] nsl_op;
  logic       nsl_rdy;

  cu_next_state_logic #(.STATE_W(6), .MEM_WAIT(1'b0)) u_nsl (
    .state(nsl_state), .op(nsl_op), .mem_ready(nsl_rdy), .ns(nsl_ns)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expectations for the current cycle of the default DUT
  bit          exp_valid = 1'b0;
  int          exp_state, exp_ns;
  bit          exp_retire;
  logic [31:0] model_cnt = '0;

  always @(negedge clk) begin
    if (exp_valid) begin
      check("state",   state,   exp_state);
      check("ns",      ns,      exp_ns);
      check("retire",  retire,  exp_retire);
      check("trap",    trap,    exp_state == 15);
      check("instret", instret, model_cnt);
    end
  end

  // Drive one cycle, publish its expectations, then advance the counter model.
  task automatic cycle(input logic [6:0] o, input logic rdy, input logic rst,
                       input int es, input int ens, input bit eret);
    op         = o;
    mem_ready  = rdy;
    reset      = rst;
    exp_state  = es;
    exp_ns     = ens;
    exp_retire = eret;
    exp_valid  = 1'b1;
    @(posedge clk);
    #1;
    model_cnt = rst ? '0 : model_cnt + (eret ? 32'd1 : 32'd0);
  endtask

  // Build the full state trace of one instruction from its class, then play it.
  task automatic run_instr(input logic [6:0] opc, input int fw, input int mw, input int hold);
    int st[$];
    bit rd[$];
    bit illegal;
    illegal = 1'b0;
    repeat (fw) begin st.push_back(0); rd.push_back(1'b0); end
    st.push_back(0); rd.push_back(1'b1);
    st.push_back(1); rd.push_back(1'b1);
    case (opc)
      OP_LOAD: begin
        st.push_back(2); rd.push_back(1'b1);
        repeat (mw) begin st.push_back(3); rd.push_back(1'b0); end
        st.push_back(3); rd.push_back(1'b1);
        st.push_back(4); rd.push_back(1'b1);
      end
      OP_STORE: begin
        st.push_back(2); rd.push_back(1'b1);
        repeat (mw) begin st.push_back(5); rd.push_back(1'b0); end
        st.push_back(5); rd.push_back(1'b1);
      end
      OP_R:      begin st.push_back(6);  st.push_back(7);  rd.push_back(1'b1); rd.push_back(1'b1); end
      OP_IMM:    begin st.push_back(13); st.push_back(7);  rd.push_back(1'b1); rd.push_back(1'b1); end
      OP_AUIPC:  begin st.push_back(11); st.push_back(7);  rd.push_back(1'b1); rd.push_back(1'b1); end
      OP_LUI:    begin st.push_back(14); st.push_back(7);  rd.push_back(1'b1); rd.push_back(1'b1); end
      OP_JAL:    begin st.push_back(9);  st.push_back(10); rd.push_back(1'b1); rd.push_back(1'b1); end
      OP_JALR:   begin st.push_back(9);  st.push_back(12); rd.push_back(1'b1); rd.push_back(1'b1); end
      OP_BRANCH: begin st.push_back(8);  rd.push_back(1'b1); end
      default: begin
        illegal = 1'b1;
        repeat (hold + 1) begin st.push_back(15); rd.push_back(1'b1); end
      end
    endcase
    for (int i = 0; i < st.size(); i++) begin
      int  ens;
      logic [6:0] o;
      ens = (i + 1 < st.size()) ? st[i+1] : (illegal ? 15 : 0);
      o   = (st[i] == 15) ? 7'($urandom) : opc;
      cycle(o, rd[i], 1'b0, st[i], ens, !illegal && (i == st.size() - 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_w[5];
    reset = 1'b1; mem_ready = 1'b1; op = OP_R;
    reset_c = 1'b1; rdy_c = 1'b1; op_c = OP_BRANCH;
    reset_w = 1'b1; rdy_w = 1'b1; op_w = OP_STORE;
    nsl_state = '0; nsl_op = '0; nsl_rdy = 1'b0;
    @(posedge clk);
    #1;
    // Held in reset: FETCH with ns=DECODE, nothing retired
    cycle(OP_R, 1'b1, 1'b1, 0, 1, 1'b0);

    run_instr(OP_R, 0, 0, 0);
    check("lit R instret", instret, 32'd1);
    run_instr(OP_LOAD, 0, 2, 0);
    check("lit load instret", instret, 32'd2);
    run_instr(OP_STORE, 1, 1, 0);
    run_instr(OP_JAL, 0, 0, 0);
    run_instr(OP_JALR, 0, 0, 0);
    run_instr(OP_AUIPC, 0, 0, 0);
    run_instr(OP_LUI, 0, 0, 0);
    run_instr(OP_IMM, 2, 0, 0);
    run_instr(OP_BRANCH, 0, 0, 0);
    check("lit nine retired", instret, 32'd9);

    // Reset in a retiring cycle clears the counter without the increment
    cycle(OP_BRANCH, 1'b1, 1'b0, 0, 1, 1'b0);
    cycle(OP_BRANCH, 1'b1, 1'b0, 1, 8, 1'b0);
    cycle(OP_BRANCH, 1'b1, 1'b1, 8, 0, 1'b1);
    check("lit rst retire instret", instret, 32'd0);

    // Reset during a MEM_READ wait
    run_instr(OP_R, 0, 0, 0);
    cycle(OP_LOAD, 1'b1, 1'b0, 0, 1, 1'b0);
    cycle(OP_LOAD, 1'b1, 1'b0, 1, 2, 1'b0);
    cycle(OP_LOAD, 1'b1, 1'b0, 2, 3, 1'b0);
    cycle(OP_LOAD, 1'b0, 1'b1, 3, 3, 1'b0);
    check("lit mid rst state", state, 32'd0);
    check("lit mid rst instret", instret, 32'd0);

    // Corrupted opcode in MEM_ADDR and in JUMP_ADDR
    cycle(OP_LOAD, 1'b1, 1'b0, 0, 1, 1'b0);
    cycle(OP_LOAD, 1'b1, 1'b0, 1, 2, 1'b0);
    cycle(OP_R,    1'b1, 1'b0, 2, 15, 1'b0);
    cycle(OP_R,    1'b1, 1'b1, 15, 15, 1'b0);
    cycle(OP_JAL,  1'b1, 1'b0, 0, 1, 1'b0);
    cycle(OP_JAL,  1'b1, 1'b0, 1, 9, 1'b0);
    cycle(OP_LUI,  1'b1, 1'b0, 9, 15, 1'b0);
    cycle(OP_LUI,  1'b1, 1'b1, 15, 15, 1'b0);

    // Illegal opcode, TRAP held for 10 cycles, then reset out
    run_instr(7'b1111111, 0, 0, 10);
    check("lit trap", trap, 32'd1);
    check("lit trap state", state, 32'd15);
    cycle(7'b1111111, 1'b1, 1'b1, 15, 15, 1'b0);
    check("lit post-trap state", state, 32'd0);
    run_instr(OP_STORE, 0, 0, 0);
    check("lit post-trap instret", instret, 32'd1);
    exp_valid = 1'b0;

    // 4-bit counter: 16 back-to-back branches wrap to 0
    @(posedge clk); #1;
    reset_c = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    check("wrap 15 branches", instret_c, 32'd15);
    check("wrap state", state_c, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("wrap 16 branches", instret_c, 32'd0);
    check("wrap trap", trap_c, 32'd0);

    // STATE_W=6, MEM_WAIT=0: store completes with mem_ready held low
    reset_w = 1'b0; rdy_w = 1'b0;
    exp_w = '{0, 1, 2, 5, 0};
    for (int i = 0; i < 5; i++) begin
      check("wide state", state_w, exp_w[i]);
      check("wide retire", retire_w, (i == 3) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    check("wide instret", instret_w, 32'd1);
    check("wide trap", trap_w, 32'd0);

    // Unused encodings and MEM_WAIT=0 on the bare next-state logic
    nsl_state = 6'd20; #1;
    check("nsl unused 20", nsl_ns, 32'd15);
    nsl_state = 6'd3;  #1;
    check("nsl memread nowait", nsl_ns, 32'd4);
    nsl_state = 6'd0;  #1;
    check("nsl fetch nowait", nsl_ns, 32'd1);
    nsl_state = 6'd15; #1;
    check("nsl trap", nsl_ns, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
